// File: rtl/cpu_run_checker_pkg.sv
// Shared definitions for the run-and-verify checker: default widths,
// FSM state encoding and a counter-width helper.
package cpu_run_checker_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int RAM_ADDR_WIDTH_DEF = 12;

  // Checker FSM states (2-bit encoding, also exported on the debug port).
  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_RUN  = 2'd1,
    CHK_SCAN = 2'd2,
    CHK_DONE = 2'd3
  } chk_state_e;

  // Bits needed to hold values 0..max_val (at least 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_run_checker_if.sv
// Bus between the checker, the core control/PC, the two RAM read ports and
// the result reporting.
//
// Handshake contract: start is a one-cycle request, accepted only while the
// checker is idle or done, and needs no acknowledge. chk_enb is a read
// strobe with no back-pressure: every cycle it is high, both RAMs must
// return the word at chk_addr on dut_dat/exp_dat exactly READ_LATENCY
// cycles later. Results (pass, timeout, err_count, first_err_addr) are
// valid while done is high.
interface cpu_run_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic [DATA_WIDTH-1:0] pc_in;
  logic                  pc_stall;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic                  chk_enb;
  logic [DATA_WIDTH-1:0] dut_dat;
  logic [DATA_WIDTH-1:0] exp_dat;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  timeout;
  logic [CNT_WIDTH-1:0]  err_count;
  logic [ADDR_WIDTH-1:0] first_err_addr;

  // Environment side: core, RAMs and whoever launches the run.
  modport master (
    output start, pc_in, dut_dat, exp_dat,
    input  pc_stall, chk_addr, chk_enb, busy, done, pass, timeout,
           err_count, first_err_addr
  );

  // Checker side.
  modport slave (
    input  start, pc_in, dut_dat, exp_dat,
    output pc_stall, chk_addr, chk_enb, busy, done, pass, timeout,
           err_count, first_err_addr
  );
endinterface

// File: rtl/cpu_run_checker_halt_detect.sv
// Halt detector: the program is halted once pc_i has matched the previous
// cycle's PC for HALT_CYCLES consecutive cycles while enabled.
module chk_halt_detect
  import cpu_run_checker_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int HALT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  halt_o
);

  localparam int HC_W = cnt_width(HALT_CYCLES);
  localparam logic [HC_W-1:0] HC_LIM = HC_W'(HALT_CYCLES - 1);

  logic [DATA_WIDTH-1:0] pc_last_q, pc_last_d;
  logic [HC_W-1:0]       stable_cnt_q, stable_cnt_d;
  logic                  pc_eq;

  assign pc_eq  = (pc_i == pc_last_q);
  assign halt_o = en_i && pc_eq && (stable_cnt_q == HC_LIM);

  // Next PC history and stable-run length; cleared when a run is launched.
  always_comb begin
    pc_last_d    = pc_last_q;
    stable_cnt_d = stable_cnt_q;
    if (clr_i) begin
      pc_last_d    = '1;
      stable_cnt_d = '0;
    end else if (en_i) begin
      pc_last_d = pc_i;
      if (!pc_eq) begin
        stable_cnt_d = '0;
      end else if (stable_cnt_q != HC_LIM) begin
        stable_cnt_d = stable_cnt_q + HC_W'(1);
      end
    end
  end

  // PC history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_last_q    <= '1;
      stable_cnt_q <= '0;
    end else begin
      pc_last_q    <= pc_last_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_checker.sv
// Run-and-verify controller: stalls the core until start, detects halt,
// then sweeps the data RAM against an expected image and reports the
// mismatch count and the first mismatching word address.
// Optional watchdog: define CPU_RUN_TIMEOUT_EN to bound the RUN phase to
// TIMEOUT_CYCLES cycles; otherwise RUN waits for halt indefinitely.
module cpu_run_checker
  import cpu_run_checker_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = RAM_ADDR_WIDTH_DEF,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int HALT_CYCLES    = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  cpu_run_checker_if.slave  bus,
  output chk_state_e        dbg_state_o
);

  // Sweep counter has one extra bit so DEPTH == 2**ADDR_WIDTH terminates.
  localparam int AC_W = ADDR_WIDTH + 1;
  localparam logic [AC_W-1:0] DEPTH_W = AC_W'(DEPTH);
  // Only the oldest pipeline slot still holds a tag.
  localparam logic [READ_LATENCY-1:0] VLD_LAST = READ_LATENCY'(1) << (READ_LATENCY - 1);

  chk_state_e state_q, state_d;

  logic                  start_acc;
  logic                  halt;
  logic                  wd_expire;
  logic                  issue;
  logic                  scan_last;
  logic                  ret_vld;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic                  word_diff;
  logic                  mismatch;

  logic [AC_W-1:0]       addr_q, addr_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] tag_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] tag_d [READ_LATENCY];
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  timeout_q, timeout_d;
  logic                  pass_q, pass_d;

  logic pc_stall, busy, done;

  assign start_acc = bus.start && ((state_q == CHK_IDLE) || (state_q == CHK_DONE));
  assign issue     = (state_q == CHK_SCAN) && (addr_q < DEPTH_W);
  assign scan_last = (state_q == CHK_SCAN) && (addr_q == DEPTH_W) && (vld_q == VLD_LAST);
  assign ret_vld   = vld_q[READ_LATENCY-1];
  assign ret_addr  = tag_q[READ_LATENCY-1];

`ifdef SYNTHESIS
  assign word_diff = (bus.dut_dat != bus.exp_dat);
`else
  // Unknown bits are treated as a mismatch in simulation.
  assign word_diff = (bus.dut_dat !== bus.exp_dat);
`endif
  assign mismatch = (state_q == CHK_SCAN) && ret_vld && word_diff;

  chk_halt_detect #(
    .DATA_WIDTH  (DATA_WIDTH),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_acc),
    .en_i   (state_q == CHK_RUN),
    .pc_i   (bus.pc_in),
    .halt_o (halt)
  );

`ifdef CPU_RUN_TIMEOUT_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog next value: counts RUN cycles since the accepted start.
  always_comb begin
    wd_d = wd_q;
    if (start_acc) begin
      wd_d = '0;
    end else if (state_q == CHK_RUN) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wd_expire = (state_q == CHK_RUN) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 1);
  assign wd_expire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CHK_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: halt or watchdog leaves RUN, drained pipeline ends SCAN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CHK_IDLE, CHK_DONE: if (bus.start) state_d = CHK_RUN;
      CHK_RUN:            if (halt || wd_expire) state_d = CHK_SCAN;
      CHK_SCAN:           if (scan_last) state_d = CHK_DONE;
      default:            state_d = CHK_IDLE;
    endcase
  end

  // FSM outputs: the core only runs in RUN.
  always_comb begin
    pc_stall = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      CHK_RUN: begin
        pc_stall = 1'b0;
        busy     = 1'b1;
      end
      CHK_SCAN: busy = 1'b1;
      CHK_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state: sweep address, tag pipeline, result accumulation.
  always_comb begin
    addr_d    = addr_q;
    err_d     = err_q;
    first_d   = first_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;

    vld_d[0] = issue;
    tag_d[0] = addr_q[ADDR_WIDTH-1:0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end

    if (state_q == CHK_RUN) begin
      addr_d = '0;
    end else if (scan_last) begin
      addr_d = '0;
    end else if (issue) begin
      addr_d = addr_q + AC_W'(1);
    end

    if (start_acc) begin
      err_d     = '0;
      first_d   = '0;
      timeout_d = 1'b0;
      pass_d    = 1'b0;
    end else begin
      if (mismatch && (err_q != '1)) begin
        err_d = err_q + CNT_WIDTH'(1);
      end
      if (mismatch && (err_q == '0)) begin
        first_d = ret_addr;
      end
      if (wd_expire && !halt) begin
        timeout_d = 1'b1;
      end
      if (scan_last) begin
        pass_d = (err_d == '0) && !timeout_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      vld_q     <= '0;
      err_q     <= '0;
      first_q   <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      addr_q    <= addr_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign bus.pc_stall       = pc_stall;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.chk_enb        = issue;
  assign bus.chk_addr       = addr_q[ADDR_WIDTH-1:0];
  assign bus.err_count      = err_q;
  assign bus.first_err_addr = first_q;
  assign bus.pass           = pass_q;
  assign bus.timeout        = timeout_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Bench for cpu_run_checker: instance A uses the default geometry
// (1024 words, latency 1, halt after 2 stable cycles); instance B is a
// 16-word, latency-2, 2-bit-counter build with HALT_CYCLES=3 and a
// 100-cycle watchdog limit.
module tb_cpu_run_checker;

  logic clk;
  logic rst_a, rst_b;
  logic [1:0] dbg_a, dbg_b;
  int total, bad;

`ifdef CPU_RUN_TIMEOUT_EN
  localparam int WD_LOOP = 100000;
  localparam int WD_RUN  = 100;
  localparam bit WD_TO   = 1'b1;
  localparam bit WD_PASS = 1'b0;
`else
  localparam int WD_LOOP = 300;
  localparam int WD_RUN  = 304;
  localparam bit WD_TO   = 1'b0;
  localparam bit WD_PASS = 1'b1;
`endif

  cpu_run_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .CNT_WIDTH(16)) if_a ();
  cpu_run_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4),  .CNT_WIDTH(2))  if_b ();

  cpu_run_checker #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(1024), .READ_LATENCY(1),
    .HALT_CYCLES(2), .CNT_WIDTH(16), .TIMEOUT_CYCLES(65536)
  ) dut_a (.clk(clk), .rst(rst_a), .bus(if_a), .dbg_state_o(dbg_a));

  cpu_run_checker #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2),
    .HALT_CYCLES(3), .CNT_WIDTH(2), .TIMEOUT_CYCLES(100)
  ) dut_b (.clk(clk), .rst(rst_b), .bus(if_b), .dbg_state_o(dbg_b));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models
  logic [31:0] dut_mem_a [1024];
  logic [31:0] exp_mem_a [1024];
  logic [31:0] dut_mem_b [16];
  logic [31:0] exp_mem_b [16];
  logic [31:0] ra_dut, ra_exp, rb1_dut, rb1_exp, rb2_dut, rb2_exp;

  always @(posedge clk) begin
    if (if_a.chk_enb) begin
      ra_dut <= dut_mem_a[if_a.chk_addr[9:0]];
      ra_exp <= exp_mem_a[if_a.chk_addr[9:0]];
    end
    if (if_b.chk_enb) begin
      rb1_dut <= dut_mem_b[if_b.chk_addr];
      rb1_exp <= exp_mem_b[if_b.chk_addr];
    end
    rb2_dut <= rb1_dut;
    rb2_exp <= rb1_exp;
  end

  assign if_a.dut_dat = ra_dut;
  assign if_a.exp_dat = ra_exp;
  assign if_b.dut_dat = rb2_dut;
  assign if_b.exp_dat = rb2_exp;

  // Launch A with a program halted at 0x40 and measure phase lengths.
  task automatic run_a(input int max_cyc, output int run_c, output int scan_c,
                       output int enb_c, output bit ok);
    run_c = 0; scan_c = 0; enb_c = 0; ok = 1'b0;
    if_a.pc_in = 32'h40;
    @(negedge clk);
    if_a.start = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if_a.start = 1'b0;
      if (if_a.busy && !if_a.pc_stall) run_c++;
      if (if_a.busy && if_a.pc_stall) scan_c++;
      if (if_a.chk_enb) enb_c++;
      if (if_a.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Launch B; mode 0 constant PC, mode 1 repeat/move/halt, mode 2 loop then halt.
  task automatic run_b(input int mode, input int loop_len, input int max_cyc,
                       output int run_c, output int scan_c, output int enb_c, output bit ok);
    run_c = 0; scan_c = 0; enb_c = 0; ok = 1'b0;
    @(negedge clk);
    if_b.start = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if_b.start = (mode == 1) && (k == 2);
      if (mode == 0) begin
        if_b.pc_in = 32'h20;
      end else if (mode == 1) begin
        case (k)
          0, 1:    if_b.pc_in = 32'h10;
          2:       if_b.pc_in = 32'h14;
          default: if_b.pc_in = 32'h18;
        endcase
      end else begin
        if (k < loop_len) if_b.pc_in = ((k % 2) == 1) ? 32'h14 : 32'h10;
        else              if_b.pc_in = 32'h20;
      end
      if (if_b.busy && !if_b.pc_stall) run_c++;
      if (if_b.busy && if_b.pc_stall) scan_c++;
      if (if_b.chk_enb) enb_c++;
      if (if_b.done) begin
        ok = 1'b1;
        break;
      end
    end
    if_b.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    total++; if (if_a.pc_stall !== 1'b1) begin bad++; $display("FAIL reset_stall: got %0b want 1", if_a.pc_stall); end
    total++; if (if_a.chk_enb !== 1'b0) begin bad++; $display("FAIL reset_enb: got %0b want 0", if_a.chk_enb); end
    total++; if (if_a.chk_addr !== 12'h000) begin bad++; $display("FAIL reset_addr: got %0h want 0", if_a.chk_addr); end
    total++; if (if_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", if_a.busy); end
    total++; if (if_a.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", if_a.done); end
    total++; if (if_a.pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %0b want 0", if_a.pass); end
    total++; if (if_a.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %0b want 0", if_a.timeout); end
    total++; if (if_a.err_count !== 16'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", if_a.err_count); end
    total++; if (if_a.first_err_addr !== 12'h000) begin bad++; $display("FAIL reset_first: got %0h want 0", if_a.first_err_addr); end
    total++; if (dbg_a !== 2'd0) begin bad++; $display("FAIL reset_state_a: got %0d want 0", dbg_a); end
    total++; if (if_b.pc_stall !== 1'b1 || if_b.busy !== 1'b0 || if_b.done !== 1'b0)
      begin bad++; $display("FAIL reset_b_ctrl: got stall=%0b busy=%0b done=%0b want 1/0/0", if_b.pc_stall, if_b.busy, if_b.done); end
  endtask

  task automatic test_all_match();
    int run_c, scan_c, enb_c; bit ok;
    run_a(3000, run_c, scan_c, enb_c, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL match_done_seen: got %0b want 1", ok); end
    total++; if (run_c != 3) begin bad++; $display("FAIL match_run_len: got %0d want 3", run_c); end
    total++; if (scan_c != 1025) begin bad++; $display("FAIL match_scan_len: got %0d want 1025", scan_c); end
    total++; if (enb_c != 1024) begin bad++; $display("FAIL match_enb_cnt: got %0d want 1024", enb_c); end
    total++; if (if_a.pass !== 1'b1) begin bad++; $display("FAIL match_pass: got %0b want 1", if_a.pass); end
    total++; if (if_a.err_count !== 16'd0) begin bad++; $display("FAIL match_err: got %0d want 0", if_a.err_count); end
    total++; if (if_a.first_err_addr !== 12'h000) begin bad++; $display("FAIL match_first: got %0h want 0", if_a.first_err_addr); end
    total++; if (dbg_a !== 2'd3) begin bad++; $display("FAIL match_state: got %0d want 3", dbg_a); end
    repeat (5) @(negedge clk);
    total++; if (if_a.done !== 1'b1 || if_a.pass !== 1'b1)
      begin bad++; $display("FAIL match_hold: got done=%0b pass=%0b want 1/1", if_a.done, if_a.pass); end
  endtask

  task automatic test_mismatch();
    int run_c, scan_c, enb_c; bit ok;
    exp_mem_a[12'h005] = exp_mem_a[12'h005] ^ 32'h0000_0001;
    exp_mem_a[12'h3FF] = exp_mem_a[12'h3FF] ^ 32'h8000_0000;
    run_a(3000, run_c, scan_c, enb_c, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mism_done_seen: got %0b want 1", ok); end
    total++; if (if_a.err_count !== 16'd2) begin bad++; $display("FAIL mism_err: got %0d want 2", if_a.err_count); end
    total++; if (if_a.first_err_addr !== 12'h005) begin bad++; $display("FAIL mism_first: got %0h want 5", if_a.first_err_addr); end
    total++; if (if_a.pass !== 1'b0) begin bad++; $display("FAIL mism_pass: got %0b want 0", if_a.pass); end
    total++; if (scan_c != 1025) begin bad++; $display("FAIL mism_scan_len: got %0d want 1025", scan_c); end
  endtask

  task automatic test_reset_mid_scan();
    int run_c, scan_c, enb_c; bit ok, found;
    if_a.pc_in = 32'h40;
    @(negedge clk); if_a.start = 1'b1;
    @(negedge clk); if_a.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (if_a.chk_enb && if_a.chk_addr == 12'h200) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_reach_200: got %0b want 1", found); end
    total++; if (if_a.err_count !== 16'd1) begin bad++; $display("FAIL rst_err_before: got %0d want 1", if_a.err_count); end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    total++; if (if_a.pc_stall !== 1'b1) begin bad++; $display("FAIL rst_stall: got %0b want 1", if_a.pc_stall); end
    total++; if (if_a.busy !== 1'b0 || if_a.done !== 1'b0)
      begin bad++; $display("FAIL rst_busy_done: got %0b/%0b want 0/0", if_a.busy, if_a.done); end
    total++; if (if_a.err_count !== 16'd0) begin bad++; $display("FAIL rst_err: got %0d want 0", if_a.err_count); end
    total++; if (if_a.chk_enb !== 1'b0) begin bad++; $display("FAIL rst_enb: got %0b want 0", if_a.chk_enb); end
    total++; if (dbg_a !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_a); end
    for (int i = 0; i < 1024; i++) exp_mem_a[i] = dut_mem_a[i];
    run_a(3000, run_c, scan_c, enb_c, ok);
    total++; if (ok !== 1'b1 || if_a.pass !== 1'b1)
      begin bad++; $display("FAIL rerun_pass: got ok=%0b pass=%0b want 1/1", ok, if_a.pass); end
    total++; if (scan_c != 1025 || if_a.err_count !== 16'd0)
      begin bad++; $display("FAIL rerun_scan: got scan=%0d err=%0d want 1025/0", scan_c, if_a.err_count); end
  endtask

  task automatic test_halt_delay();
    int run_c, scan_c, enb_c; bit ok;
    run_b(1, 0, 200, run_c, scan_c, enb_c, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL hdly_done_seen: got %0b want 1", ok); end
    total++; if (run_c != 7) begin bad++; $display("FAIL hdly_run_len: got %0d want 7", run_c); end
    total++; if (scan_c != 18) begin bad++; $display("FAIL hdly_scan_len: got %0d want 18", scan_c); end
    total++; if (enb_c != 16) begin bad++; $display("FAIL hdly_enb_cnt: got %0d want 16", enb_c); end
    total++; if (if_b.pass !== 1'b1 || if_b.err_count !== 2'd0)
      begin bad++; $display("FAIL hdly_result: got pass=%0b err=%0d want 1/0", if_b.pass, if_b.err_count); end
  endtask

  task automatic test_saturate();
    int run_c, scan_c, enb_c; bit ok;
    exp_mem_b[3]  = exp_mem_b[3]  ^ 32'h1;
    exp_mem_b[4]  = exp_mem_b[4]  ^ 32'h100;
    exp_mem_b[7]  = exp_mem_b[7]  ^ 32'hFFFF_0000;
    exp_mem_b[10] = exp_mem_b[10] ^ 32'h8000_0000;
    exp_mem_b[15] = exp_mem_b[15] ^ 32'h2;
    run_b(0, 0, 200, run_c, scan_c, enb_c, ok);
    total++; if (run_c != 4) begin bad++; $display("FAIL sat_run_len: got %0d want 4", run_c); end
    total++; if (if_b.err_count !== 2'd3) begin bad++; $display("FAIL sat_err: got %0d want 3", if_b.err_count); end
    total++; if (if_b.first_err_addr !== 4'h3) begin bad++; $display("FAIL sat_first: got %0h want 3", if_b.first_err_addr); end
    total++; if (if_b.pass !== 1'b0 || ok !== 1'b1)
      begin bad++; $display("FAIL sat_pass: got pass=%0b ok=%0b want 0/1", if_b.pass, ok); end
  endtask

  task automatic test_watchdog();
    int run_c, scan_c, enb_c; bit ok;
    for (int i = 0; i < 16; i++) exp_mem_b[i] = dut_mem_b[i];
    run_b(2, WD_LOOP, 600, run_c, scan_c, enb_c, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wd_done_seen: got %0b want 1", ok); end
    total++; if (run_c != WD_RUN) begin bad++; $display("FAIL wd_run_len: got %0d want %0d", run_c, WD_RUN); end
    total++; if (scan_c != 18) begin bad++; $display("FAIL wd_scan_len: got %0d want 18", scan_c); end
    total++; if (if_b.timeout !== WD_TO) begin bad++; $display("FAIL wd_timeout: got %0b want %0b", if_b.timeout, WD_TO); end
    total++; if (if_b.pass !== WD_PASS) begin bad++; $display("FAIL wd_pass: got %0b want %0b", if_b.pass, WD_PASS); end
    total++; if (if_b.err_count !== 2'd0) begin bad++; $display("FAIL wd_err: got %0d want 0", if_b.err_count); end
  endtask

  initial begin
    total = 0; bad = 0;
    if_a.start = 1'b0; if_a.pc_in = 32'h0;
    if_b.start = 1'b0; if_b.pc_in = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      dut_mem_a[i] = $urandom;
      exp_mem_a[i] = dut_mem_a[i];
    end
    for (int i = 0; i < 16; i++) begin
      dut_mem_b[i] = $urandom;
      exp_mem_b[i] = dut_mem_b[i];
    end
    test_reset();
    test_all_match();
    test_mismatch();
    test_reset_mid_scan();
    test_halt_delay();
    test_saturate();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
